// File: rtl/embedding_lookup.sv
// Embedding lookup: accepts a token index, reads EMB_DIM elements from an external
// table (1-cycle read latency) and presents the assembled vector downstream.
module embedding_lookup #(
  parameter int VOCAB   = 39,
  parameter int EMB_DIM = 4,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tok_valid,
  output logic                      tok_ready,
  input  logic [5:0]                tok_idx,
  output logic                      emb_rd,
  output logic [5:0]                emb_row,
  output logic [1:0]                emb_col,
  input  logic [DATA_W-1:0]         emb_rdata,
  output logic                      vec_valid,
  input  logic                      vec_ready,
  output logic [EMB_DIM*DATA_W-1:0] vec_data,
  output logic                      err_oob,
  output logic [15:0]               vec_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [1:0] LAST_COL = 2'(EMB_DIM - 1);

  logic [1:0] state;
  logic       cap_en;   // a read was issued last cycle, its data is on emb_rdata now
  logic [1:0] cap_col;  // column of that read
  logic       accept;
  logic       in_range;

  assign tok_ready = (state == IDLE);
  assign emb_rd    = (state == FETCH);
  assign vec_valid = (state == OUT);
  assign accept    = tok_valid && tok_ready;
  assign in_range  = {26'd0, tok_idx} < 32'(VOCAB);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make cap_col see the updated emb_col.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      emb_row   <= '0;
      emb_col   <= '0;
      err_oob   <= 1'b0;
      cap_en    <= 1'b0;
      cap_col   <= '0;
      vec_data  <= '0;
      vec_count <= '0;
    end else begin
      err_oob <= 1'b0;
      cap_en  <= emb_rd;
      cap_col <= emb_col;

      for (int k = 0; k < EMB_DIM; k++) begin
        if (cap_en && cap_col == 2'(k)) vec_data[k*DATA_W +: DATA_W] <= emb_rdata;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              emb_row <= tok_idx;
              emb_col <= '0;
              state   <= FETCH;
            end else begin
              err_oob <= 1'b1;
            end
          end
        end
        FETCH: begin
          // Column counter parks on the last column so emb_col holds once reads stop.
          if (emb_col == LAST_COL) state <= DRAIN;
          else                     emb_col <= emb_col + 2'd1;
        end
        DRAIN: state <= OUT;
        OUT: begin
          if (vec_ready) begin
            vec_count <= vec_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_embedding_lookup.sv
// Self-checking bench for embedding_lookup: random table contents behind a 1-cycle
// read-latency responder, expected vectors taken straight from the table rows.
module tb_embedding_lookup;

  localparam int VW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          tok_valid;
  logic          tok_ready;
  logic [5:0]    tok_idx;
  logic          emb_rd;
  logic [5:0]    emb_row;
  logic [1:0]    emb_col;
  logic [15:0]   emb_rdata;
  logic          vec_valid;
  logic          vec_ready;
  logic [VW-1:0] vec_data;
  logic          err_oob;
  logic [15:0]   vec_count;

  embedding_lookup dut (
    .clk       (clk),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_idx   (tok_idx),
    .emb_rd    (emb_rd),
    .emb_row   (emb_row),
    .emb_col   (emb_col),
    .emb_rdata (emb_rdata),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .err_oob   (err_oob),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_count = 16'd0;

  logic [15:0] rom [64][4];

  // Table responder: data for a read appears one cycle later; otherwise noise.
  always @(posedge clk) begin
    if (emb_rd) emb_rdata <= rom[emb_row][emb_col];
    else        emb_rdata <= 16'($urandom);
  end

  int acc_cnt = 0, rd_cnt = 0, oob_cnt = 0, vv_cnt = 0, nrdy_cnt = 0, bad_cnt = 0;
  logic [VW-1:0] hs_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (tok_valid && tok_ready) acc_cnt++;
      if (emb_rd)     rd_cnt++;
      if (err_oob)    oob_cnt++;
      if (vec_valid)  vv_cnt++;
      if (!tok_ready) nrdy_cnt++;
      if (tok_ready && (emb_rd || vec_valid)) bad_cnt++;
      if (vec_valid && vec_ready) hs_q.push_back(vec_data);
    end
  end

  function automatic logic [VW-1:0] exp_vec(input int i);
    return {rom[i][3], rom[i][2], rom[i][1], rom[i][0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one token, follows it to delivery and reports what it observed.
  task automatic send_token(input int idx, input int hold, output int lat,
                            output logic [VW-1:0] data, output int nr,
                            output bit reads_ok, output bit stable, output bit idle_ok);
    logic [1:0] cexp;
    tick();
    tok_idx   = 6'(idx);
    tok_valid = 1'b1;
    vec_ready = (hold == 0);
    tick();
    tok_valid = 1'b0;
    lat = -1; nr = 0; reads_ok = 1'b1; stable = 1'b0; idle_ok = 1'b0; data = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (emb_rd) begin
        cexp = nr[1:0];
        if (c != nr + 1 || emb_col !== cexp || emb_row !== 6'(idx)) reads_ok = 1'b0;
        nr++;
      end
      if (vec_valid) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) return;
    data   = vec_data;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      @(negedge clk);
      if (!vec_valid || vec_data !== data || tok_ready) stable = 1'b0;
    end
    if (hold > 0) begin
      tick();
      vec_ready = 1'b1;
    end
    tick();
    vec_ready = 1'b0;
    @(negedge clk);
    idle_ok = tok_ready && !vec_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; tok_valid = 1'b1; tok_idx = 6'd5; vec_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (tok_ready !== 1'b1 || emb_rd !== 1'b0 || emb_row !== 6'd0 || emb_col !== 2'd0 ||
        vec_valid !== 1'b0 || vec_data !== '0 || err_oob !== 1'b0 || vec_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b rd=%b row=%0d col=%0d vv=%b data=%h oob=%b cnt=%0d, want rdy=1 rest 0",
               tok_ready, emb_rd, emb_row, emb_col, vec_valid, vec_data, err_oob, vec_count);
    end
    tick();
    rst = 1'b0; tok_valid = 1'b0; vec_ready = 1'b0;
  endtask

  task automatic test_oob();
    int r0, v0, n0, o0;
    int toks[2] = '{39, 63};
    r0 = rd_cnt; v0 = vv_cnt; n0 = nrdy_cnt; o0 = oob_cnt;
    foreach (toks[t]) begin
      tick();
      tok_idx = 6'(toks[t]); tok_valid = 1'b1;
      tick();
      tok_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (err_oob !== 1'b1 || tok_ready !== 1'b1) begin
        errors++;
        $display("FAIL oob_pulse tok=%0d: err_oob=%b tok_ready=%b, want 1 1", toks[t], err_oob, tok_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if (err_oob !== 1'b0) begin
        errors++;
        $display("FAIL oob_pulse_end tok=%0d: err_oob=%b, want 0", toks[t], err_oob);
      end
    end
    checks++;
    if (rd_cnt != r0 || vv_cnt != v0 || nrdy_cnt != n0 || oob_cnt != o0 + 2) begin
      errors++;
      $display("FAIL oob_side_effects: reads=%0d valids=%0d not_ready=%0d pulses=%0d, want 0 0 0 2",
               rd_cnt - r0, vv_cnt - v0, nrdy_cnt - n0, oob_cnt - o0);
    end
    checks++;
    if (emb_row !== 6'd0 || emb_col !== 2'd0) begin
      errors++;
      $display("FAIL oob_addr_hold: row=%0d col=%0d, want 0 0", emb_row, emb_col);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int v0;
    v0 = vv_cnt;
    tick();
    tok_idx = 6'd5; tok_valid = 1'b1; vec_ready = 1'b1;
    tick();
    tok_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (emb_rd !== 1'b1 || emb_col !== 2'd2) begin
      errors++;
      $display("FAIL rst_fetch_phase: rd=%b col=%0d, want 1 2", emb_rd, emb_col);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tok_ready !== 1'b1 || emb_rd !== 1'b0 || emb_row !== 6'd0 || emb_col !== 2'd0 ||
        vec_valid !== 1'b0 || vec_data !== '0 || err_oob !== 1'b0 || vec_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_fetch: rdy=%b rd=%b row=%0d col=%0d vv=%b data=%h oob=%b cnt=%0d, want rdy=1 rest 0",
               tok_ready, emb_rd, emb_row, emb_col, vec_valid, vec_data, err_oob, vec_count);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (vv_cnt != v0 || vec_count !== exp_count) begin
      errors++;
      $display("FAIL rst_no_vector: valid_cycles=%0d cnt=%0d, want 0 %0d", vv_cnt - v0, vec_count, exp_count);
    end
    vec_ready = 1'b0;
  endtask

  task automatic test_single(input int idx, input int hold, input string name);
    int lat, nr;
    logic [VW-1:0] data;
    bit reads_ok, stable, idle_ok;
    send_token(idx, hold, lat, data, nr, reads_ok, stable, idle_ok);
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want 6", name, lat);
      return;
    end
    exp_count++;
    checks++;
    if (!reads_ok || nr != 4) begin
      errors++;
      $display("FAIL %s_reads: reads=%0d ordered=%b, want 4 reads cols 0..3 row %0d", name, nr, reads_ok, idx);
    end
    checks++;
    if (data !== exp_vec(idx)) begin
      errors++;
      $display("FAIL %s_data: got %h, want %h", name, data, exp_vec(idx));
    end
    checks++;
    if (!stable || !idle_ok) begin
      errors++;
      $display("FAIL %s_hold: stable=%b idle_after=%b, want 1 1", name, stable, idle_ok);
    end
    checks++;
    if (vec_count !== exp_count) begin
      errors++;
      $display("FAIL %s_count: got %h, want %h", name, vec_count, exp_count);
    end
  endtask

  task automatic test_row36();
    int lat, nr;
    logic [VW-1:0] data;
    bit reads_ok, stable, idle_ok;
    send_token(36, 0, lat, data, nr, reads_ok, stable, idle_ok);
    if (lat == 6) exp_count++;
    checks++;
    if (lat != 6 || !reads_ok || nr != 4) begin
      errors++;
      $display("FAIL row36_timing: latency=%0d reads=%0d ordered=%b, want 6 4 1", lat, nr, reads_ok);
    end
    checks++;
    if (data !== 64'h011D_01B3_01E9_01EB) begin
      errors++;
      $display("FAIL row36_data: got %h, want 011d01b301e901eb", data);
    end
    checks++;
    if (vec_count !== 16'd1) begin
      errors++;
      $display("FAIL row36_count: got %0d, want 1", vec_count);
    end
  endtask

  task automatic test_back_to_back();
    int toks[3] = '{38, 1, 37};
    int a0;
    bit got;
    a0 = acc_cnt;
    hs_q.delete();
    tick();
    vec_ready = 1'b1;
    tok_valid = 1'b1;
    foreach (toks[t]) begin
      tok_idx = 6'(toks[t]);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = tok_ready;
        tick();
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL b2b_accept tok=%0d: not accepted within 40 cycles", toks[t]);
      end
    end
    tok_valid = 1'b0;
    for (int c = 0; c < 40 && hs_q.size() < 3; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    vec_ready = 1'b0;
    checks++;
    if (acc_cnt - a0 != 3 || hs_q.size() != 3 || bad_cnt != 0) begin
      errors++;
      $display("FAIL b2b_flow: accepts=%0d vectors=%0d ready_outside_idle=%0d, want 3 3 0",
               acc_cnt - a0, hs_q.size(), bad_cnt);
    end
    foreach (toks[t]) begin
      if (t < hs_q.size()) begin
        exp_count++;
        checks++;
        if (hs_q[t] !== exp_vec(toks[t])) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %h, want %h", t, hs_q[t], exp_vec(toks[t]));
        end
      end
    end
    checks++;
    if (vec_count !== exp_count) begin
      errors++;
      $display("FAIL b2b_count: got %0d, want %0d", vec_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    // Jump straight to the wrap point instead of delivering 65534 vectors.
    tick();
    force dut.vec_count = 16'hFFFE;
    #1;
    release dut.vec_count;
    exp_count = 16'hFFFE;
    test_single(17, 0, "wrap_ffff");
    test_single(2, 0, "wrap_0000");
    checks++;
    if (vec_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: got %h, want 0000", vec_count);
    end
  endtask

  initial begin
    for (int r = 0; r < 64; r++)
      for (int k = 0; k < 4; k++) rom[r][k] = 16'($urandom);
    rom[36][0] = 16'h01EB; rom[36][1] = 16'h01E9;
    rom[36][2] = 16'h01B3; rom[36][3] = 16'h011D;
    rom[38][3] = 16'h8001;  // negative element must pass through unchanged

    rst = 1'b1; tok_valid = 1'b0; tok_idx = 6'd0; vec_ready = 1'b0;
    test_reset();
    test_oob();
    test_reset_mid_fetch();
    test_row36();
    test_single(0, 10, "hold");
    test_back_to_back();
    for (int i = 0; i < 4; i++) test_single(int'($urandom_range(0, 38)), int'($urandom_range(0, 3)), "random");
    test_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/embedding_lookup.md
EMBEDDING_LOOKUP -- requirements
Module: embedding_lookup

Interface
REQ-001 SHALL have parameter VOCAB, default 39, meaning the number of valid token indices (0..VOCAB-1).
REQ-002 SHALL have parameter EMB_DIM, default 4, meaning the number of elements per embedding vector.
REQ-003 SHALL have parameter DATA_W, default 16, meaning the element width (two's-complement fixed point).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-006 SHALL have port tok_valid, input, 1, meaning a token index is offered.
REQ-007 SHALL have port tok_ready, output, 1, meaning the block accepts a token this cycle.
REQ-008 SHALL have port tok_idx, input, 6, the token index.
REQ-009 SHALL have port emb_rd, output, 1, the table read strobe.
REQ-010 SHALL have port emb_row, output, 6, the table row address (token index).
REQ-011 SHALL have port emb_col, output, 2, the table element address.
REQ-012 SHALL have port emb_rdata, input, DATA_W, the table read data, valid exactly 1 cycle after emb_rd.
REQ-013 SHALL have port vec_valid, output, 1, meaning the embedding vector is presented downstream.
REQ-014 SHALL have port vec_ready, input, 1, meaning downstream (RNN cell) accepts the vector.
REQ-015 SHALL have port vec_data, output, EMB_DIM*DATA_W, the vector; element k occupies bits [k*DATA_W +: DATA_W].
REQ-016 SHALL have port err_oob, output, 1, a one-cycle pulse for an out-of-range token.
REQ-017 SHALL have port vec_count, output, 16, the count of vectors delivered.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, DRAIN, OUT.
REQ-019 SHALL assert tok_ready only in IDLE; a token is accepted when tok_valid and tok_ready are both high at a rising edge.
REQ-020 SHALL latch tok_idx on acceptance; an accepted index < VOCAB SHALL go to FETCH with column counter = 0.
REQ-021 SHALL, for an accepted index >= VOCAB, issue no reads, pulse err_oob high for exactly the next cycle, and remain in IDLE.
REQ-022 SHALL, in FETCH, drive emb_rd=1, emb_row=latched index, emb_col=counter, and increment the counter each cycle over 0..EMB_DIM-1.
REQ-023 SHALL go from FETCH to DRAIN after issuing column EMB_DIM-1.
REQ-024 SHALL capture emb_rdata into element (col of previous cycle's read) each cycle following an emb_rd=1 cycle.
REQ-025 SHALL go from DRAIN to OUT after one cycle, the last element being captured in DRAIN.
REQ-026 SHALL hold vec_valid=1 and vec_data stable in OUT until vec_ready=1, with latency from the acceptance edge to the first vec_valid=1 cycle equal to EMB_DIM+2 cycles.
REQ-027 SHALL, on the vec_valid and vec_ready handshake, increment vec_count (wrapping 0xFFFF->0) and return to IDLE on the next cycle.
REQ-028 SHALL keep emb_rd=0 outside FETCH, and emb_row/emb_col SHALL hold their last values when emb_rd=0.
REQ-029 SHALL pass elements unmodified (no sign change, no scaling).
REQ-030 SHALL, when tok_valid is high in a non-IDLE state, neither accept nor disturb the token; it is held by upstream.

Reset
REQ-031 SHALL, when rst=1 at an edge, enter IDLE with tok_ready=1, emb_rd=0, emb_row=0, emb_col=0, vec_valid=0, vec_data=0, err_oob=0, vec_count=0.
REQ-032 SHALL give rst priority over all other inputs; reset mid-FETCH or in OUT SHALL abandon the vector without delivering it and without incrementing the count.

Verification
REQ-033 Bench ROM row 36 = 0x01EB,0x01E9,0x01B3,0x011D; tok_idx=36 with vec_ready=1 -> reads at cols 0..3 on 4 consecutive cycles, vec_valid 6 cycles after acceptance, vec_data=0x011D_01B3_01E9_01EB, vec_count=1.
REQ-034 tok_idx=39, then 63 -> err_oob one-cycle pulse each, emb_rd never high, vec_valid never high, tok_ready=1 throughout.
REQ-035 Token 0 accepted, vec_ready held 0 for 10 cycles -> vec_valid and vec_data stable for 10 cycles, tok_ready=0; vec_ready=1 -> handshake, then IDLE next cycle.
REQ-036 rst=1 pulsed during the third FETCH cycle -> all outputs at reset values next cycle, no vector emitted, vec_count unchanged at 0.
REQ-037 Tokens 38, 1, 37 back-to-back with tok_valid held high -> each accepted only in IDLE, three vectors match the ROM rows in order, vec_count=3.
REQ-038 Preload vec_count to 0xFFFF by delivering 65535 vectors, then one more -> vec_count=0x0000.
